// File: rtl/sf_pkg.sv
// rtl/sf_pkg.sv - shared field widths, constants and enums for the single-precision multiplier
package sf_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_MULT,
        ST_NORM,
        ST_ROUND
    } state_t;

    // Subnormals (exp=0, frac!=0) deliberately classify as zero: they are flushed.
    function automatic op_class_t classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        if (e == '0) begin
            return CLS_ZERO;
        end
        if (e == '1) begin
            return (f == '0) ? CLS_INF : CLS_NAN;
        end
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/sf_round_pack.sv
// rtl/sf_round_pack.sv - round-to-nearest-even, exponent range check and IEEE-754 packing
module sf_round_pack
    import sf_pkg::*;
(
    input  logic               sign_i,
    input  logic signed [9:0]  exp_i,
    input  logic [22:0]        frac_i,
    input  logic               guard_i,
    input  logic               sticky_i,
    output logic [31:0]        word_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    logic              round_up;
    logic [23:0]       sum;
    logic signed [9:0] exp_r;

    assign round_up = guard_i & (sticky_i | frac_i[0]);
    assign sum      = {1'b0, frac_i} + {23'd0, round_up};
    // A carry out leaves sum[22:0] at zero, which is exactly the renormalised fraction.
    assign exp_r    = exp_i + $signed({9'd0, sum[23]});

    always_comb begin
        overflow_o  = (exp_r >= 10'sd255);
        underflow_o = !overflow_o && (exp_r <= 10'sd0);
        word_o      = {sign_i, exp_r[7:0], sum[22:0]};
        if (overflow_o) begin
            word_o = POS_INF | {sign_i, 31'd0};
        end else if (underflow_o) begin
            word_o = {sign_i, 31'd0};
        end
    end

endmodule

// File: rtl/sf_mul_core.sv
// rtl/sf_mul_core.sv - sequential single-precision multiplier behind the operation_nd/operation_rfd/rdy handshake
module sf_mul_core #(
    parameter int SF_WIDTH = 32,
    parameter int LATENCY  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SF_WIDTH-1:0] a,
    input  logic [SF_WIDTH-1:0] b,
    input  logic                operation_nd,
    output logic                operation_rfd,
    output logic [SF_WIDTH-1:0] result,
    output logic                rdy,
    output logic                underflow,
    output logic                overflow,
    output logic                invalid_op
);
    import sf_pkg::*;

    if (SF_WIDTH != 32 || LATENCY != 4) begin : g_bad_params
        $error("sf_mul_core supports only SF_WIDTH=32 and LATENCY=4");
    end

    state_t            state_q, state_d;
    logic [31:0]       op_a_q, op_b_q;
    logic              sign_q;
    op_class_t         cls_a_q, cls_b_q, cls_a_d, cls_b_d;
    logic [23:0]       mant_a_q, mant_b_q;
    logic signed [9:0] exp_q, exp_raw;
    logic [22:0]       frac_q;
    logic              guard_q, sticky_q;
    logic [47:0]       prod;
    logic [31:0]       result_q, res_d, rp_word;
    logic              rdy_q, uf_q, of_q, inv_q;
    logic              uf_d, of_d, inv_d, rp_of, rp_uf;
    logic              accept;

    assign operation_rfd = (state_q == ST_IDLE);
    assign accept        = operation_rfd && operation_nd;

    // Normalisation shares the MULT cycle so one transaction spans exactly four cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (operation_nd) state_d = ST_UNPACK;
            ST_UNPACK: state_d = ST_MULT;
            ST_MULT:   state_d = ST_ROUND;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign cls_a_d = classify(op_a_q[30:23], op_a_q[22:0]);
    assign cls_b_d = classify(op_b_q[30:23], op_b_q[22:0]);
    assign prod    = {24'd0, mant_a_q} * {24'd0, mant_b_q};
    assign exp_raw = $signed({2'b00, op_a_q[30:23]}) + $signed({2'b00, op_b_q[30:23]}) - 10'sd127;

    sf_round_pack u_round_pack (
        .sign_i      (sign_q),
        .exp_i       (exp_q),
        .frac_i      (frac_q),
        .guard_i     (guard_q),
        .sticky_i    (sticky_q),
        .word_o      (rp_word),
        .overflow_o  (rp_of),
        .underflow_o (rp_uf)
    );

    always_comb begin
        res_d = rp_word;
        uf_d  = rp_uf;
        of_d  = rp_of;
        inv_d = 1'b0;
        if (cls_a_q == CLS_NAN || cls_b_q == CLS_NAN ||
            (cls_a_q == CLS_INF && cls_b_q == CLS_ZERO) ||
            (cls_a_q == CLS_ZERO && cls_b_q == CLS_INF)) begin
            res_d = QNAN;
            uf_d  = 1'b0;
            of_d  = 1'b0;
            inv_d = 1'b1;
        end else if (cls_a_q == CLS_INF || cls_b_q == CLS_INF) begin
            res_d = POS_INF | {sign_q, 31'd0};
            uf_d  = 1'b0;
            of_d  = 1'b0;
        end else if (cls_a_q == CLS_ZERO || cls_b_q == CLS_ZERO) begin
            res_d = {sign_q, 31'd0};
            uf_d  = 1'b0;
            of_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sign_q   <= 1'b0;
            cls_a_q  <= CLS_ZERO;
            cls_b_q  <= CLS_ZERO;
            mant_a_q <= '0;
            mant_b_q <= '0;
            exp_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
            rdy_q    <= 1'b0;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_q == ST_ROUND);
            if (accept) begin
                op_a_q <= a;
                op_b_q <= b;
            end
            if (state_q == ST_UNPACK) begin
                sign_q   <= op_a_q[31] ^ op_b_q[31];
                cls_a_q  <= cls_a_d;
                cls_b_q  <= cls_b_d;
                mant_a_q <= (cls_a_d == CLS_NORM) ? {1'b1, op_a_q[22:0]} : 24'd0;
                mant_b_q <= (cls_b_d == CLS_NORM) ? {1'b1, op_b_q[22:0]} : 24'd0;
            end
            if (state_q == ST_MULT) begin
                if (prod[47]) begin
                    exp_q    <= exp_raw + 10'sd1;
                    frac_q   <= prod[46:24];
                    guard_q  <= prod[23];
                    sticky_q <= |prod[22:0];
                end else begin
                    exp_q    <= exp_raw;
                    frac_q   <= prod[45:23];
                    guard_q  <= prod[22];
                    sticky_q <= |prod[21:0];
                end
            end
            if (state_q == ST_ROUND) begin
                result_q <= res_d;
                uf_q     <= uf_d;
                of_q     <= of_d;
                inv_q    <= inv_d;
            end
        end
    end

    assign result     = result_q;
    assign rdy        = rdy_q;
    assign underflow  = uf_q;
    assign overflow   = of_q;
    assign invalid_op = inv_q;

endmodule

// File: tb/tb_sf_mul_core.sv
// tb/tb_sf_mul_core.sv - scoreboard bench for sf_mul_core
module tb_sf_mul_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        operation_nd;
    logic        operation_rfd;
    logic [31:0] result;
    logic        rdy, underflow, overflow, invalid_op;

    always #5 clk = ~clk;

    sf_mul_core #(.SF_WIDTH(32), .LATENCY(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .operation_nd  (operation_nd),
        .operation_rfd (operation_rfd),
        .result        (result),
        .rdy           (rdy),
        .underflow     (underflow),
        .overflow      (overflow),
        .invalid_op    (invalid_op)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        uf;
        logic        of;
        logic        inv;
        bit          junk;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [34:0] exp_q[$];
    int          exp_cyc_q[$];
    vec_t        vecs[$];
    logic [34:0] mon_e;
    int          mon_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("result", result, mon_e[31:0]);
                check("flags_inv_of_uf", {29'd0, invalid_op, overflow, underflow}, {29'd0, mon_e[34:32]});
                check("rdy_cycle", cyc, mon_c);
            end
        end
    end

    task automatic run_op(input vec_t v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (operation_rfd !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (operation_rfd !== 1'b1) begin
            check("rfd_timeout", {31'd0, operation_rfd}, 32'd1);
            return;
        end
        a = v.a;
        b = v.b;
        operation_nd = 1'b1;
        exp_q.push_back({v.inv, v.of, v.uf, v.res});
        exp_cyc_q.push_back(cyc + 4);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("rfd_busy", {31'd0, operation_rfd}, 32'd0);
            a = $urandom;
            b = $urandom;
            operation_nd = (v.junk && i < 3);
        end
    endtask

    initial begin
        vec_t v;
        int   waited;
        rst = 1'b1;
        operation_nd = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_rfd", {31'd0, operation_rfd}, 32'd1);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {29'd0, invalid_op, overflow, underflow}, 32'd0);
        rst = 1'b0;

        vecs.push_back('{32'h4120_0000, 32'h4000_0000, 32'h41A0_0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{32'h0000_0001, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h3F80_0800, 32'h3F80_0800, 32'h3F80_1000, 1'b0, 1'b0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            run_op(vecs[i]);
        end

        // Abort a transaction with reset two cycles after its accept.
        @(negedge clk);
        waited = 0;
        while (operation_rfd !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        a = 32'h4120_0000;
        b = 32'h4000_0000;
        operation_nd = 1'b1;
        @(negedge clk);
        operation_nd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rfd", {31'd0, operation_rfd}, 32'd1);
        check("abort_rdy", {31'd0, rdy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {29'd0, invalid_op, overflow, underflow}, 32'd0);
        repeat (6) @(negedge clk);

        v = '{32'hC000_0000, 32'h4000_0000, 32'hC080_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        run_op(v);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
